// File: rtl/stpu_div_pkg.sv
// Shared definitions for the STPU multi-cycle divider: FSM encodings,
// handshake level names and the default datapath width.
package stpu_div_pkg;

  // Divider FSM encodings (2-bit).
  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

  // Level names used on the ready/start handshake.
  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

  // Default operand width; the {remainder, quotient} bus is twice this.
  localparam int DIV_WIDTH_DEFAULT  = 32;
  localparam int DOUBLE_REG_BUS_W   = 2 * DIV_WIDTH_DEFAULT;

endpackage : stpu_div_pkg

// File: rtl/stpu_div_step.sv
// One radix-2 restoring division step: trial-subtract the divisor from the
// upper WIDTH+1 bits of the partial remainder, then shift in one quotient bit.
// Kept purely combinational so a radix-4 divider can chain two of them.
module stpu_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH:0]  rem_i,
  input  logic [WIDTH-1:0]  divisor_i,
  output logic [2*WIDTH:0]  rem_o
);

  logic [WIDTH:0]   rem_hi;
  logic             fits;
  logic [WIDTH-1:0] diff;

  assign rem_hi = rem_i[2*WIDTH:WIDTH];

  // rem_hi can reach almost 2*divisor, so the fit test is done at full
  // WIDTH+1 precision; when it fits, the difference is below the divisor
  // and its low WIDTH bits are the whole result.
  assign fits = (rem_hi >= {1'b0, divisor_i});
  assign diff = rem_hi[WIDTH-1:0] - divisor_i;

  // Shift left by one, inserting the quotient bit at the bottom.
  always_comb begin
    rem_o = {rem_i[2*WIDTH-1:0], 1'b0};
    if (fits) begin
      rem_o = {diff, rem_i[WIDTH-1:0], 1'b1};
    end
  end

endmodule : stpu_div_step

// File: rtl/stpu_div.sv
// STPU multi-cycle signed/unsigned integer divider.
// Handshake: EX raises start_i with both operands and keeps it high until it
// sees ready_o; the result then stays stable until EX drops start_i, after
// which the divider returns to FREE and needs one idle cycle before the next
// start. annul_i cancels work in BYZERO/ON but is ignored once in END.
module stpu_div
  import stpu_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output div_state_e         state_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  div_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   divisor_q, divisor_d;
  logic               neg_quot_q, neg_quot_d;
  logic               neg_rem_q, neg_rem_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ready_q, ready_d;

  logic [2*WIDTH:0]   step_rem;
  logic [WIDTH-1:0]   mag1, mag2;
  logic [WIDTH-1:0]   quot_raw, rem_raw;
  logic [WIDTH-1:0]   quot_fix, rem_fix;
  logic               accept;

  // Operand magnitudes: signed negatives are converted to their magnitude so
  // the core iteration is always unsigned.
  assign mag1 = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
  assign mag2 = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
  assign accept = (start_i == DIV_START) && !annul_i;

  // After WIDTH steps the quotient sits in the low bits and the remainder
  // in the bits above the shifted-out dividend slot.
  assign quot_raw = rem_q[WIDTH-1:0];
  assign rem_raw  = rem_q[2*WIDTH:WIDTH+1];
  assign quot_fix = neg_quot_q ? -quot_raw : quot_raw;
  assign rem_fix  = neg_rem_q  ? -rem_raw  : rem_raw;

  stpu_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .divisor_i (divisor_q),
    .rem_o     (step_rem)
  );

  // Next-state and datapath-next logic for the divider FSM.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    divisor_d  = divisor_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    result_d   = result_q;
    ready_d    = ready_q;
    unique case (state_q)
      DIV_FREE: begin
        result_d = '0;
        ready_d  = DIV_RESULT_NOT_READY;
        if (accept) begin
          if (opdata2_i == '0) begin
            state_d = DIV_BYZERO;
          end else begin
            state_d    = DIV_ON;
            cnt_d      = '0;
            divisor_d  = mag2;
            rem_d      = {{WIDTH{1'b0}}, mag1, 1'b0};
            neg_quot_d = signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            neg_rem_d  = signed_div_i && opdata1_i[WIDTH-1];
          end
        end
      end
      DIV_BYZERO: begin
        // Result is zero; ready is raised by END on the following edge.
        result_d = '0;
        ready_d  = DIV_RESULT_NOT_READY;
        if (annul_i) begin
          state_d = DIV_FREE;
        end else begin
          state_d = DIV_END;
        end
      end
      DIV_ON: begin
        if (annul_i) begin
          state_d  = DIV_FREE;
          cnt_d    = '0;
          result_d = '0;
          ready_d  = DIV_RESULT_NOT_READY;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = DIV_END;
          cnt_d    = '0;
          result_d = {rem_fix, quot_fix};
          ready_d  = DIV_RESULT_READY;
        end else begin
          rem_d = step_rem;
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      DIV_END: begin
        if (start_i == DIV_STOP) begin
          state_d  = DIV_FREE;
          result_d = '0;
          ready_d  = DIV_RESULT_NOT_READY;
        end else begin
          ready_d = DIV_RESULT_READY;
        end
      end
      default: begin
        state_d  = DIV_FREE;
        cnt_d    = '0;
        result_d = '0;
        ready_d  = DIV_RESULT_NOT_READY;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously by rst low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= DIV_FREE;
      cnt_q      <= '0;
      rem_q      <= '0;
      divisor_q  <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_q   <= '0;
      ready_q    <= DIV_RESULT_NOT_READY;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      divisor_q  <= divisor_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;
  assign state_o  = state_q;

endmodule : stpu_div

// File: tb/tb_stpu_div.sv
// Directed, table-driven bench for stpu_div plus hand-written sequences for
// annul, asynchronous reset and back-to-back issue.
module tb_stpu_div;
  import stpu_div_pkg::*;

  localparam int W = 32;
  localparam int MAX_WAIT = 40;

  logic           clk = 1'b0;
  logic           rst;
  logic           signed_div;
  logic [W-1:0]   op1, op2;
  logic           start, annul;
  logic [2*W-1:0] result;
  logic           ready;
  div_state_e     dbg_state;

  logic [2*W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic           sgn;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] exp;
    int             lat;
  } vec_t;

  vec_t vecs[15];

  stpu_div #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready),
    .state_o      (dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive a request; it is sampled at the next rising edge (E0).
  task automatic launch(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    signed_div = sgn;
    op1        = a;
    op2        = b;
    start      = 1'b1;
    tick();
    // Operands must be ignored once accepted.
    op1 = $urandom;
    op2 = $urandom;
  endtask

  // Count edges after E0 until ready_o is seen, bounded.
  task automatic wait_ready(output int lat);
    lat = 0;
    while (!ready && lat < MAX_WAIT) begin
      tick();
      lat++;
    end
  endtask

  // Full transaction: issue, wait, check, hold start, drop start, check clear.
  task automatic run_div(input string name, input logic sgn, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [2*W-1:0] exp,
                         input int exp_lat, output int lat);
    logic [2*W-1:0] want;
    exp_q.push_back(exp);
    launch(sgn, a, b);
    wait_ready(lat);
    want = exp_q.pop_front();
    check({name, "_latency"}, 64'(lat), 64'(exp_lat));
    check({name, "_result"}, result, want);
    for (int i = 0; i < 3; i++) begin
      tick();
      check({name, "_hold_ready"}, 64'(ready), 64'(1));
      check({name, "_hold_result"}, result, want);
    end
    start = 1'b0;
    tick();
    check({name, "_drop_ready"}, 64'(ready), 64'(0));
    check({name, "_drop_result"}, result, 64'(0));
    check({name, "_drop_state"}, 64'(dbg_state), 64'(DIV_FREE));
  endtask

  initial begin
    int lat, lat2;
    int seen;

    vecs[0]  = '{1'b0, 32'd100,        32'd7,          {32'd2,        32'd14},        33};
    vecs[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33};
    vecs[2]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  {32'h0000_0001, 32'hFFFF_FFFD}, 33};
    vecs[3]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  {32'h0,         32'h8000_0000}, 33};
    vecs[4]  = '{1'b0, 32'd5,          32'd0,          64'h0,                          2};
    vecs[5]  = '{1'b0, 32'hFFFF_FFFF,  32'd3,          {32'h0,         32'h5555_5555}, 33};
    vecs[6]  = '{1'b0, 32'hFFFF_FFFF,  32'h10,         {32'hF,         32'h0FFF_FFFF}, 33};
    vecs[7]  = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  {32'hFFFF_FFFE, 32'd14},        33};
    vecs[8]  = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  {32'h8000_0000, 32'h0},         33};
    vecs[9]  = '{1'b0, 32'd3,          32'd7,          {32'd3,         32'd0},         33};
    vecs[10] = '{1'b1, 32'hFFFF_FFFF,  32'd0,          64'h0,                          2};
    vecs[11] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          {32'h0,         32'hFFFF_FFFF}, 33};
    vecs[12] = '{1'b0, 32'hFFFF_FFFF,  32'h8000_0001,  {32'h7FFF_FFFE, 32'd1},         33};
    vecs[13] = '{1'b0, 32'hFFFF_FFFE,  32'hFFFF_FFFF,  {32'hFFFF_FFFE, 32'h0},         33};
    vecs[14] = '{1'b1, 32'h7FFF_FFFF,  32'hFFFF_FFFF,  {32'h0,         32'h8000_0001}, 33};

    // reset
    rst = 1'b0; signed_div = 1'b0; op1 = '0; op2 = '0; start = 1'b0; annul = 1'b0;
    repeat (2) tick();
    check("reset_ready", 64'(ready), 64'(0));
    check("reset_result", result, 64'(0));
    check("reset_state", 64'(dbg_state), 64'(DIV_FREE));
    rst = 1'b1;
    tick();

    // table-driven vectors, issued back to back with one idle cycle between
    for (int i = 0; i < 15; i++) begin
      run_div($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b,
              vecs[i].exp, vecs[i].lat, lat);
    end

    // back-to-back latency equality
    run_div("b2b_first", 1'b0, 32'd1000, 32'd9, {32'd1, 32'd111}, 33, lat);
    run_div("b2b_second", 1'b1, 32'hFFFF_FC18, 32'd9, {32'hFFFF_FFFF, 32'hFFFF_FF91}, 33, lat2);
    check("b2b_same_latency", 64'(lat2), 64'(lat));

    // annul mid-iteration: no result, then a fresh division works
    launch(1'b0, 32'hFFFF_FFFF, 32'd3);
    repeat (10) tick();
    annul = 1'b1;
    start = 1'b0;
    tick();
    annul = 1'b0;
    check("annul_on_state", 64'(dbg_state), 64'(DIV_FREE));
    check("annul_on_ready", 64'(ready), 64'(0));
    seen = 0;
    repeat (MAX_WAIT) begin
      tick();
      if (ready) seen = 1;
    end
    check("annul_never_ready", 64'(seen), 64'(0));
    run_div("after_annul", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33, lat);

    // annul together with start in FREE: request is not taken
    signed_div = 1'b0; op1 = 32'd50; op2 = 32'd5; start = 1'b1; annul = 1'b1;
    tick();
    check("annul_free_state", 64'(dbg_state), 64'(DIV_FREE));
    start = 1'b0; annul = 1'b0;
    tick();

    // annul in BYZERO
    launch(1'b0, 32'd5, 32'd0);
    check("byzero_state", 64'(dbg_state), 64'(DIV_BYZERO));
    annul = 1'b1; start = 1'b0;
    tick();
    annul = 1'b0;
    check("annul_byzero_state", 64'(dbg_state), 64'(DIV_FREE));
    check("annul_byzero_ready", 64'(ready), 64'(0));

    // annul in END is ignored
    launch(1'b0, 32'd100, 32'd7);
    wait_ready(lat);
    annul = 1'b1;
    tick();
    annul = 1'b0;
    check("annul_end_ready", 64'(ready), 64'(1));
    check("annul_end_result", result, {32'd2, 32'd14});
    start = 1'b0;
    tick();

    // async reset while in END: outputs clear before any clock edge
    launch(1'b0, 32'd100, 32'd7);
    wait_ready(lat);
    #2 rst = 1'b0;
    #1;
    check("rst_end_ready", 64'(ready), 64'(0));
    check("rst_end_result", result, 64'(0));
    check("rst_end_state", 64'(dbg_state), 64'(DIV_FREE));
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();

    // async reset mid-ON
    launch(1'b0, 32'd100, 32'd7);
    repeat (15) tick();
    check("pre_rst_on_state", 64'(dbg_state), 64'(DIV_ON));
    #2 rst = 1'b0;
    #1;
    check("rst_on_state", 64'(dbg_state), 64'(DIV_FREE));
    check("rst_on_ready", 64'(ready), 64'(0));
    check("rst_on_result", result, 64'(0));
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    run_div("after_rst", 1'b0, 32'd1, 32'd1, {32'd0, 32'd1}, 33, lat);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_stpu_div
